// File: rtl/mem_access_if.sv
// Data-memory request/ack bus: the MEM stage drives the master side, data memory the slave side.
interface mem_access_if #(parameter int DMEM_AW = 32);
    logic               req;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic               ack;
    logic [31:0]        rdata;

    modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_access.sv
// RV32I MEM stage: dmem load/store over req/ack, branch resolve, MEM/WB register (MEM_MISALIGN_TRAP_EN adds misalign abort).
// Latency: 1 cycle for non-memory ops; memory ops complete on the dmem ack cycle, later if keep is held then.
// Backpressure: stall_out freezes upstream while an access is outstanding; keep holds MEM/WB, load data parks in a hold reg.
module mem_access #(
    parameter int ACK_TIMEOUT = 16,
    parameter int DMEM_AW     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [31:0] PCp4_pype2,
    input  logic [31:0] PCBranch_pype,
    input  logic [4:0]  WReg_pype2,
    input  logic        RegWrite_pype2,
    input  logic [1:0]  MemtoReg_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [2:0]  MemBranch_pype2,
    input  logic [2:0]  mem_size_pype2,
    mem_access_if.master dmem,
    output logic        stall_out,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic [31:0] WB_data_pype3,
    output logic [4:0]  WReg_pype3,
    output logic        RegWrite_pype3,
    output logic        mem_err
);
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] pcp4;
        logic [31:0] target;
        logic [4:0]  wreg;
        logic        regwrite;
        logic [1:0]  memtoreg;
        logic [1:0]  memrw;
        logic [2:0]  membranch;
        logic [2:0]  size;
    } exmem_t;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state;
    exmem_t      cur, lat, op;
    logic [31:0] hold_q, tmo_cnt, rd_word, ld_val, wb_val, addr_al;
    logic        mem_op, mis, issue, timeout, abort, cap, bubble, wb_we, req;

    function automatic logic is_mem(input logic [1:0] rw);
        return (rw == 2'b01) || (rw == 2'b10);
    endfunction

    function automatic logic br_taken(input logic [2:0] mb, input logic [31:0] alu);
        case (mb)
            3'b001, 3'b101: return alu == 32'd0;
            3'b010:         return alu != 32'd0;
            3'b011:         return alu == 32'd1;
            3'b100, 3'b110: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] sz, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sft;
        logic [15:0] h;
        sft = w >> {a, 3'b000};
        h   = a[1] ? w[31:16] : w[15:0];
        case (sz)
            3'b000:  return {{24{sft[7]}}, sft[7:0]};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, sft[7:0]};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        cur = '{alu: ALU_co_pype, rs2: read_data2_pype2, pcp4: PCp4_pype2, target: PCBranch_pype,
                wreg: WReg_pype2, regwrite: RegWrite_pype2, memtoreg: MemtoReg_pype2,
                memrw: MemRW_pype2, membranch: MemBranch_pype2, size: mem_size_pype2};
        // While an access is in flight everything comes from the snapshot taken at issue.
        op     = (state == IDLE) ? cur : lat;
        mem_op = is_mem(cur.memrw) && !nop;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = ((cur.size[1:0] == 2'b01) && cur.alu[0]) ||
              ((cur.size[1:0] == 2'b10) && (cur.alu[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        issue   = (state == IDLE) && mem_op && !mis;
        timeout = (state == WAIT) && !dmem.ack && (ACK_TIMEOUT != 0) &&
                  (tmo_cnt == 32'(ACK_TIMEOUT - 1));
        abort   = timeout || ((state == IDLE) && mem_op && mis);
        cap     = !keep && (((state == IDLE) && !nop && !issue) ||
                            ((state == WAIT) && (dmem.ack || timeout)) ||
                            (state == HOLD));
        bubble  = !keep && (state == IDLE) && nop;
        // Stall drops on the completing cycle so upstream advances exactly once per access.
        stall_out = !rst && (issue ||
                             ((state == WAIT) && !(dmem.ack && !keep) && !timeout) ||
                             ((state == HOLD) && keep));

        rd_word = (state == HOLD) ? hold_q : dmem.rdata;
        ld_val  = load_ext(op.size, op.alu[1:0], rd_word);
        case (op.memtoreg)
            2'b01:   wb_val = ld_val;
            2'b10:   wb_val = op.pcp4;
            default: wb_val = op.alu;
        endcase
        wb_we = op.regwrite && (op.memrw != 2'b10) && !abort;

        addr_al = op.alu;
        if (op.size[1:0] == 2'b10)      addr_al[1:0] = 2'b00;
        else if (op.size[1:0] == 2'b01) addr_al[0]   = 1'b0;

        req        = !rst && (issue || (state == WAIT));
        dmem.req   = req;
        dmem.we    = req && (op.memrw == 2'b10);
        dmem.addr  = req ? addr_al[DMEM_AW-1:0] : '0;
        dmem.wdata = '0;
        dmem.wstrb = '0;
        if (req && (op.memrw == 2'b10)) begin
            case (op.size[1:0])
                2'b00: begin
                    dmem.wdata = {4{op.rs2[7:0]}};
                    dmem.wstrb = 4'b0001 << op.alu[1:0];
                end
                2'b01: begin
                    dmem.wdata = {2{op.rs2[15:0]}};
                    dmem.wstrb = op.alu[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    dmem.wdata = op.rs2;
                    dmem.wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat            <= '0;
            hold_q         <= '0;
            tmo_cnt        <= '0;
            WB_data_pype3  <= '0;
            WReg_pype3     <= '0;
            RegWrite_pype3 <= 1'b0;
            branch_taken   <= 1'b0;
            branch_target  <= '0;
            mem_err        <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            mem_err      <= timeout || (abort && cap);
            case (state)
                IDLE: if (issue) begin
                    lat     <= cur;
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: if (dmem.ack) begin
                    hold_q <= dmem.rdata;
                    state  <= keep ? HOLD : IDLE;
                end else if (timeout) begin
                    state <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
                HOLD: if (!keep) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (cap) begin
                WB_data_pype3  <= wb_val;
                WReg_pype3     <= op.wreg;
                RegWrite_pype3 <= wb_we;
                branch_taken   <= !abort && br_taken(op.membranch, op.alu);
                branch_target  <= op.target;
            end else if (bubble) begin
                WB_data_pype3  <= '0;
                WReg_pype3     <= '0;
                RegWrite_pype3 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: expected MEM/WB results queued at drive time and compared when the stage completes.
module tb_mem_access;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        keep, nop;
    logic [31:0] ALU_co_pype, read_data2_pype2, PCp4_pype2, PCBranch_pype;
    logic [4:0]  WReg_pype2;
    logic        RegWrite_pype2;
    logic [1:0]  MemtoReg_pype2, MemRW_pype2;
    logic [2:0]  MemBranch_pype2, mem_size_pype2;
    logic        stall_out, branch_taken, RegWrite_pype3, mem_err;
    logic [31:0] branch_target, WB_data_pype3;
    logic [4:0]  WReg_pype3;

    always #5 clk = ~clk;

    mem_access_if #(.DMEM_AW(32)) dmem_bus ();

    mem_access #(.ACK_TIMEOUT(TMO), .DMEM_AW(32)) dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop),
        .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
        .PCp4_pype2(PCp4_pype2), .PCBranch_pype(PCBranch_pype),
        .WReg_pype2(WReg_pype2), .RegWrite_pype2(RegWrite_pype2),
        .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
        .MemBranch_pype2(MemBranch_pype2), .mem_size_pype2(mem_size_pype2),
        .dmem(dmem_bus),
        .stall_out(stall_out), .branch_taken(branch_taken), .branch_target(branch_target),
        .WB_data_pype3(WB_data_pype3), .WReg_pype3(WReg_pype3),
        .RegWrite_pype3(RegWrite_pype3), .mem_err(mem_err)
    );

    typedef struct { logic [31:0] wb; logic [4:0] wr; logic we; } exp_t;
    exp_t sb_q[$];
    exp_t e;
    int n_vec = 0;
    int n_err = 0;
    int stalls, reqs;
    logic done, err_seen, ob_we;
    logic [31:0] ob_addr, ob_wdata, wb_keep;
    logic [3:0]  ob_wstrb;

    logic [2:0]  ld_sz  [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] ld_ad  [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] ld_exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};

    task automatic set_idle();
        ALU_co_pype = '0; read_data2_pype2 = '0; PCp4_pype2 = '0; PCBranch_pype = '0;
        WReg_pype2 = '0; RegWrite_pype2 = 1'b0; MemtoReg_pype2 = 2'b00; MemRW_pype2 = 2'b00;
        MemBranch_pype2 = 3'b000; mem_size_pype2 = 3'b000; nop = 1'b0; keep = 1'b0;
    endtask

    // Drives one memory op; memory acks after lat WAIT cycles (lat<0: never), keep held kc cycles from the ack.
    task automatic do_mem(input logic [1:0] rw, input logic [2:0] sz, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [1:0] m2r, input logic rwe,
                          input logic [4:0] wr, input int lat, input int kc, input logic [31:0] rdata);
        @(negedge clk);
        set_idle();
        MemRW_pype2 = rw; mem_size_pype2 = sz; ALU_co_pype = alu; read_data2_pype2 = rs2;
        MemtoReg_pype2 = m2r; RegWrite_pype2 = rwe; WReg_pype2 = wr;
        stalls = 0; reqs = 0; done = 1'b0; wb_keep = 32'hFFFF_FFFF;
        for (int c = 0; c < 64 && !done; c++) begin
            dmem_bus.ack   = (lat >= 0) && (c == lat + 1);
            dmem_bus.rdata = dmem_bus.ack ? rdata : 32'h5A5A_5A5A;
            keep           = (lat >= 0) && (c >= lat + 1) && (c < lat + 1 + kc);
            #1;
            if (stall_out) stalls++;
            if (dmem_bus.req) reqs++;
            if (keep) wb_keep = WB_data_pype3;
            if (c == 0) begin
                ob_addr = dmem_bus.addr; ob_we = dmem_bus.we;
                ob_wdata = dmem_bus.wdata; ob_wstrb = dmem_bus.wstrb;
            end
            if (c > 0 && !stall_out) done = 1'b1;
            @(negedge clk);
        end
        dmem_bus.ack = 1'b0;
        set_idle();
        #1;
        err_seen = mem_err;
    endtask

    task automatic test_reset();
        set_idle();
        MemRW_pype2 = 2'b01; mem_size_pype2 = 3'b010; ALU_co_pype = 32'h100; RegWrite_pype2 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_out); end
        n_vec++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", dmem_bus.req); end
        n_vec++; if (RegWrite_pype3 !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got %b want 0", RegWrite_pype3); end
        n_vec++; if (WB_data_pype3 !== 32'h0) begin n_err++; $display("FAIL reset_wb got %h want 0", WB_data_pype3); end
        n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL reset_branch got %b want 0", branch_taken); end
        n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_memerr got %b want 0", mem_err); end
        set_idle();
        rst = 1'b0;
    endtask

    task automatic test_alu_back_to_back();
        logic [31:0] alu_t [4] = '{32'h1111_2222, 32'hAAAA_0000, 32'h0000_0F0F, 32'h8000_0001};
        logic [31:0] pc_t  [4] = '{32'h104, 32'h208, 32'h30C, 32'h410};
        logic [1:0]  m2r_t [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
        logic        we_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0]  wr_t  [4] = '{5'd3, 5'd31, 5'd7, 5'd17};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_idle();
            ALU_co_pype = alu_t[i]; PCp4_pype2 = pc_t[i]; MemtoReg_pype2 = m2r_t[i];
            RegWrite_pype2 = we_t[i]; WReg_pype2 = wr_t[i];
            sb_q.push_back('{(m2r_t[i] == 2'b10) ? pc_t[i] : alu_t[i], wr_t[i], we_t[i]});
            #1;
            n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL alu_stall[%0d] got %b want 0", i, stall_out); end
            n_vec++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL alu_req[%0d] got %b want 0", i, dmem_bus.req); end
            @(negedge clk);
            e = sb_q.pop_front();
            n_vec++; if (WB_data_pype3 !== e.wb) begin n_err++; $display("FAIL alu_wb[%0d] got %h want %h", i, WB_data_pype3, e.wb); end
            n_vec++; if (WReg_pype3 !== e.wr) begin n_err++; $display("FAIL alu_wreg[%0d] got %0d want %0d", i, WReg_pype3, e.wr); end
            n_vec++; if (RegWrite_pype3 !== e.we) begin n_err++; $display("FAIL alu_we[%0d] got %b want %b", i, RegWrite_pype3, e.we); end
        end
        set_idle();
    endtask

    task automatic test_load();
        sb_q.push_back('{32'hDEAD_BEEF, 5'd5, 1'b1});
        do_mem(2'b01, 3'b010, 32'h100, 32'h0, 2'b01, 1'b1, 5'd5, 3, 0, 32'hDEAD_BEEF);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL lw_done got %b want 1", done); end
        n_vec++; if (stalls != 4) begin n_err++; $display("FAIL lw_stall_cycles got %0d want 4", stalls); end
        n_vec++; if (ob_addr !== 32'h100) begin n_err++; $display("FAIL lw_addr got %h want 100", ob_addr); end
        n_vec++; if (ob_we !== 1'b0 || ob_wstrb !== 4'b0000) begin n_err++; $display("FAIL lw_we_strb got %b/%b want 0/0000", ob_we, ob_wstrb); end
        e = sb_q.pop_front();
        n_vec++; if (WB_data_pype3 !== e.wb) begin n_err++; $display("FAIL lw_wb got %h want %h", WB_data_pype3, e.wb); end
        n_vec++; if (RegWrite_pype3 !== e.we || WReg_pype3 !== e.wr) begin n_err++; $display("FAIL lw_we got %b/%0d want %b/%0d", RegWrite_pype3, WReg_pype3, e.we, e.wr); end
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{ld_exp[i], 5'(6 + i), 1'b1});
            do_mem(2'b01, ld_sz[i], ld_ad[i], 32'h0, 2'b01, 1'b1, 5'(6 + i), 1, 0, 32'h80FF_FFFF);
            e = sb_q.pop_front();
            n_vec++; if (WB_data_pype3 !== e.wb) begin n_err++; $display("FAIL ld_ext[%0d] got %h want %h", i, WB_data_pype3, e.wb); end
            n_vec++; if (WReg_pype3 !== e.wr) begin n_err++; $display("FAIL ld_wreg[%0d] got %0d want %0d", i, WReg_pype3, e.wr); end
        end
        sb_q.push_back('{32'h0123_4567, 5'd9, 1'b1});
        do_mem(2'b01, 3'b010, 32'h106, 32'h0, 2'b01, 1'b1, 5'd9, 0, 0, 32'h0123_4567);
        n_vec++; if (ob_addr !== 32'h104) begin n_err++; $display("FAIL lw_unaligned_addr got %h want 104", ob_addr); end
        e = sb_q.pop_front();
        n_vec++; if (WB_data_pype3 !== e.wb) begin n_err++; $display("FAIL lw_unaligned_wb got %h want %h", WB_data_pype3, e.wb); end
    endtask

    task automatic test_store();
        logic [2:0]  sz_t [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] ad_t [3] = '{32'h002, 32'h101, 32'h104};
        logic [31:0] rs_t [3] = '{32'h1234_ABCD, 32'hCAFE_00EF, 32'h1122_3344};
        logic [31:0] wd_t [3] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'h1122_3344};
        logic [3:0]  st_t [3] = '{4'b1100, 4'b0010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{ad_t[i], 5'(20 + i), 1'b0});
            do_mem(2'b10, sz_t[i], ad_t[i], rs_t[i], 2'b00, 1'b1, 5'(20 + i), 0, 0, 32'h0);
            n_vec++; if (ob_wdata !== wd_t[i]) begin n_err++; $display("FAIL st_wdata[%0d] got %h want %h", i, ob_wdata, wd_t[i]); end
            n_vec++; if (ob_wstrb !== st_t[i]) begin n_err++; $display("FAIL st_wstrb[%0d] got %b want %b", i, ob_wstrb, st_t[i]); end
            n_vec++; if (ob_we !== 1'b1) begin n_err++; $display("FAIL st_we[%0d] got %b want 1", i, ob_we); end
            n_vec++; if (stalls != 1) begin n_err++; $display("FAIL st_stall[%0d] got %0d want 1", i, stalls); end
            e = sb_q.pop_front();
            n_vec++; if (RegWrite_pype3 !== e.we) begin n_err++; $display("FAIL st_regwrite[%0d] got %b want %b", i, RegWrite_pype3, e.we); end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  mb_t  [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        logic [31:0] alu_t [6] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd5, 32'd0};
        logic        tk_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_idle();
            ALU_co_pype = alu_t[i]; MemBranch_pype2 = mb_t[i]; PCBranch_pype = 32'h40 + 32'(i * 4);
            @(negedge clk);
            set_idle();
            n_vec++; if (branch_taken !== tk_t[i]) begin n_err++; $display("FAIL br_taken[%0d] got %b want %b", i, branch_taken, tk_t[i]); end
            if (tk_t[i]) begin
                n_vec++; if (branch_target !== 32'h40 + 32'(i * 4)) begin n_err++; $display("FAIL br_target[%0d] got %h want %h", i, branch_target, 32'h40 + 32'(i * 4)); end
                @(negedge clk);
                n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL br_pulse[%0d] got %b want 0", i, branch_taken); end
            end
        end
        @(negedge clk);
        set_idle();
        MemBranch_pype2 = 3'b110; PCBranch_pype = 32'h80; RegWrite_pype2 = 1'b1; WReg_pype2 = 5'd9; nop = 1'b1;
        @(negedge clk);
        set_idle();
        n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL nop_branch got %b want 0", branch_taken); end
        n_vec++; if (RegWrite_pype3 !== 1'b0 || WReg_pype3 !== 5'd0) begin n_err++; $display("FAIL nop_bubble got %b/%0d want 0/0", RegWrite_pype3, WReg_pype3); end
    endtask

    task automatic test_keep_hold();
        sb_q.push_back('{32'h0BAD_F00D, 5'd11, 1'b1});
        do_mem(2'b01, 3'b010, 32'h200, 32'h0, 2'b01, 1'b1, 5'd11, 1, 2, 32'h0BAD_F00D);
        n_vec++; if (stalls != 4) begin n_err++; $display("FAIL hold_stall got %0d want 4", stalls); end
        n_vec++; if (reqs != 3) begin n_err++; $display("FAIL hold_req_cycles got %0d want 3", reqs); end
        n_vec++; if (wb_keep !== 32'h0) begin n_err++; $display("FAIL hold_wb_frozen got %h want 0", wb_keep); end
        e = sb_q.pop_front();
        n_vec++; if (WB_data_pype3 !== e.wb) begin n_err++; $display("FAIL hold_wb got %h want %h", WB_data_pype3, e.wb); end
        n_vec++; if (RegWrite_pype3 !== e.we || WReg_pype3 !== e.wr) begin n_err++; $display("FAIL hold_we got %b/%0d want %b/%0d", RegWrite_pype3, WReg_pype3, e.we, e.wr); end
    endtask

    task automatic test_timeout();
        sb_q.push_back('{32'h0, 5'd12, 1'b0});
        do_mem(2'b01, 3'b010, 32'h300, 32'h0, 2'b01, 1'b1, 5'd12, -1, 0, 32'h0);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL tmo_done got %b want 1", done); end
        n_vec++; if (reqs != TMO + 1) begin n_err++; $display("FAIL tmo_req_cycles got %0d want %0d", reqs, TMO + 1); end
        n_vec++; if (stalls != TMO) begin n_err++; $display("FAIL tmo_stall got %0d want %0d", stalls, TMO); end
        n_vec++; if (err_seen !== 1'b1) begin n_err++; $display("FAIL tmo_memerr got %b want 1", err_seen); end
        e = sb_q.pop_front();
        n_vec++; if (RegWrite_pype3 !== e.we) begin n_err++; $display("FAIL tmo_regwrite got %b want %b", RegWrite_pype3, e.we); end
        @(negedge clk);
        n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse got %b want 0", mem_err); end
    endtask

    task automatic test_rst_in_wait();
        @(negedge clk);
        set_idle();
        MemRW_pype2 = 2'b01; mem_size_pype2 = 3'b010; ALU_co_pype = 32'h400; MemtoReg_pype2 = 2'b01; RegWrite_pype2 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (dmem_bus.req !== 1'b1) begin n_err++; $display("FAIL rstw_req_before got %b want 1", dmem_bus.req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        ALU_co_pype = 32'h55; RegWrite_pype2 = 1'b1; WReg_pype2 = 5'd4;
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hFFFF_0000;
        #1;
        n_vec++; if (dmem_bus.req !== 1'b0 || stall_out !== 1'b0) begin n_err++; $display("FAIL rstw_idle got req=%b stall=%b want 0/0", dmem_bus.req, stall_out); end
        @(negedge clk);
        dmem_bus.ack = 1'b0;
        set_idle();
        n_vec++; if (WB_data_pype3 !== 32'h55 || RegWrite_pype3 !== 1'b1) begin n_err++; $display("FAIL rstw_stray_ack got %h/%b want 00000055/1", WB_data_pype3, RegWrite_pype3); end
        n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rstw_memerr got %b want 0", mem_err); end
    endtask

    initial begin
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = '0;
        set_idle();
        test_reset();
        test_alu_back_to_back();
        test_load();
        test_store();
        test_branch();
        test_keep_hold();
        test_timeout();
        test_rst_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench did not complete");
    end
endmodule
